// File: rtl/gbdmg_vgm_player.sv
// VGM (DMG subset) byte-stream player: decodes register writes and waits for the DMG sound block.
// Optional GBDMG_VGM_PAUSE_EN adds in_pause, which freezes sample time and stream intake.
module gbdmg_vgm_player #(
   parameter logic [15:0] CLKS_PER_SAMPLE = 16'd544
) (
   input  logic       in_clk,
   input  logic       in_rst,
`ifdef GBDMG_VGM_PAUSE_EN
   input  logic       in_pause,
`endif
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       out_ready,
   output logic [5:0] out_reg,
   output logic [7:0] out_val,
   output logic       out_wr,
   output logic       out_busy,
   output logic       out_done,
   output logic       out_error
);

   // state       | meaning
   // FETCH_CMD   | waiting for a command byte
   // FETCH_ARG1  | waiting for aa (write) or count[7:0] (0x61)
   // FETCH_ARG2  | waiting for dd (write) or count[15:8] (0x61)
   // WRITE       | reg/val presented; strobe rises on leaving this state
   // WRITE_GAP   | strobe high for this clock, low again on exit
   // WAIT        | counting sample ticks down to zero
   // DONE        | 0x66 seen, terminal
   // ERROR       | unsupported command seen, terminal
   typedef enum logic [2:0] {
      S_FETCH_CMD,
      S_FETCH_ARG1,
      S_FETCH_ARG2,
      S_WRITE,
      S_WRITE_GAP,
      S_WAIT,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  addr_q, addr_d;
   logic        op_wr_q, op_wr_d;
   logic [5:0]  reg_q, reg_d;
   logic [7:0]  val_q, val_d;
   logic        wr_q, wr_d;

   logic pause;
   logic tick;
   logic fetch;
   logic ready;
   logic accept;

`ifdef GBDMG_VGM_PAUSE_EN
   assign pause = in_pause;
`else
   assign pause = 1'b0;
`endif

   assign tick   = (div_q == 16'd0) && !pause;
   assign fetch  = (state_q == S_FETCH_CMD) || (state_q == S_FETCH_ARG1) ||
                   (state_q == S_FETCH_ARG2);
   assign ready  = fetch && !pause;
   assign accept = in_valid && ready;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      op_wr_d = op_wr_q;
      reg_d   = reg_q;
      val_d   = val_q;
      wr_d    = 1'b0;

      if (pause)
         div_d = div_q;
      else if (div_q == 16'd0)
         div_d = CLKS_PER_SAMPLE - 16'd1;
      else
         div_d = div_q - 16'd1;

      case (state_q)
         S_FETCH_CMD: begin
            if (accept) begin
               case (in_data)
                  8'hB3: begin
                     op_wr_d = 1'b1;
                     state_d = S_FETCH_ARG1;
                  end
                  8'h61: begin
                     op_wr_d = 1'b0;
                     state_d = S_FETCH_ARG1;
                  end
                  8'h62: begin
                     count_d = 16'd735;
                     state_d = S_WAIT;
                  end
                  8'h63: begin
                     count_d = 16'd882;
                     state_d = S_WAIT;
                  end
                  8'h66:   state_d = S_DONE;
                  default: begin
                     if (in_data[7:4] == 4'h7) begin
                        count_d = {12'd0, in_data[3:0]} + 16'd1;
                        state_d = S_WAIT;
                     end else begin
                        state_d = S_ERROR;
                     end
                  end
               endcase
            end
         end
         S_FETCH_ARG1: begin
            if (accept) begin
               if (op_wr_q)
                  addr_d = in_data;
               else
                  count_d = {count_q[15:8], in_data};
               state_d = S_FETCH_ARG2;
            end
         end
         S_FETCH_ARG2: begin
            if (accept) begin
               if (op_wr_q) begin
                  // Addresses beyond the sound block's register window are dropped silently.
                  if (addr_q <= 8'h3F) begin
                     reg_d   = addr_q[5:0];
                     val_d   = in_data;
                     state_d = S_WRITE;
                  end else begin
                     state_d = S_FETCH_CMD;
                  end
               end else begin
                  count_d = {in_data, count_q[7:0]};
                  state_d = ({in_data, count_q[7:0]} == 16'd0) ? S_FETCH_CMD : S_WAIT;
               end
            end
         end
         S_WRITE: begin
            wr_d    = 1'b1;
            state_d = S_WRITE_GAP;
         end
         S_WRITE_GAP: state_d = S_FETCH_CMD;
         S_WAIT: begin
            if (tick) begin
               count_d = count_q - 16'd1;
               if (count_q <= 16'd1)
                  state_d = S_FETCH_CMD;
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_FETCH_CMD;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q <= S_FETCH_CMD;
         div_q   <= 16'd0;
         count_q <= 16'd0;
         addr_q  <= 8'd0;
         op_wr_q <= 1'b0;
         reg_q   <= 6'd0;
         val_q   <= 8'd0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         op_wr_q <= op_wr_d;
         reg_q   <= reg_d;
         val_q   <= val_d;
         wr_q    <= wr_d;
      end
   end

   assign out_ready = ready;
   assign out_reg   = reg_q;
   assign out_val   = val_q;
   assign out_wr    = wr_q;
   assign out_busy  = (state_q == S_WAIT);
   assign out_done  = (state_q == S_DONE);
   assign out_error = (state_q == S_ERROR);

endmodule

// File: tb/tb_gbdmg_vgm_player.sv
// Bench for gbdmg_vgm_player: stream-level model checked every cycle plus directed literal checks.
// Build with GBDMG_VGM_PAUSE_EN defined to include the pause scenario.
module tb_gbdmg_vgm_player;

   localparam int CPS = 4;

   logic       clk = 1'b0;
   logic       in_rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       pause_v;
   logic       out_ready;
   logic [5:0] out_reg;
   logic [7:0] out_val;
   logic       out_wr;
   logic       out_busy;
   logic       out_done;
   logic       out_error;

   always #5 clk = ~clk;

   gbdmg_vgm_player #(.CLKS_PER_SAMPLE(16'd4)) dut (
      .in_clk    (clk),
      .in_rst    (in_rst),
`ifdef GBDMG_VGM_PAUSE_EN
      .in_pause  (pause_v),
`endif
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .out_reg   (out_reg),
      .out_val   (out_val),
      .out_wr    (out_wr),
      .out_busy  (out_busy),
      .out_done  (out_done),
      .out_error (out_error)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stream-level model: interprets accepted bytes as VGM commands, counts sample time.
   bit          m_live = 0;
   int unsigned m_run;
   int          m_phase, m_wait;
   bit          m_done, m_err, m_have;
   logic [7:0]  m_cmd;
   logic [7:0]  m_args [2];
   int          m_nargs;
   logic [5:0]  e_reg;
   logic [7:0]  e_val;

   int         pulses = 0;
   logic [5:0] cap_reg [16];
   logic [7:0] cap_val [16];
   int         low_run = 0, min_low = 1000;
   bit         prev_wr = 0, prev_busy = 0;
   int         busy_run = 0, last_busy_len = 0, busy_events = 0;

   task automatic model_consume(input logic [7:0] b);
      if (!m_have) begin
         if (b == 8'hB3 || b == 8'h61) begin
            m_have = 1; m_cmd = b; m_nargs = 0;
         end else if (b == 8'h62) m_wait = 735;
         else if (b == 8'h63) m_wait = 882;
         else if (b >= 8'h70 && b <= 8'h7F) m_wait = int'(b) - 'h70 + 1;
         else if (b == 8'h66) m_done = 1;
         else m_err = 1;
      end else begin
         m_args[m_nargs] = b;
         m_nargs++;
         if (m_nargs == 2) begin
            m_have = 0;
            if (m_cmd == 8'hB3) begin
               if (m_args[0] < 8'h40) begin
                  e_reg = m_args[0][5:0];
                  e_val = m_args[1];
                  m_phase = 2;
               end
            end else begin
               m_wait = int'(m_args[1]) * 256 + int'(m_args[0]);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      bit tick;
      if (m_live) begin
         check("ready", out_ready, (m_phase == 0 && m_wait == 0 && !m_done && !m_err && !pause_v));
         check("busy",  out_busy,  m_wait > 0);
         check("wr",    out_wr,    m_phase == 1);
         check("reg",   out_reg,   e_reg);
         check("val",   out_val,   e_val);
         check("done",  out_done,  m_done);
         check("error", out_error, m_err);
      end
      if (out_wr && !prev_wr) begin
         if (pulses < 16) begin
            cap_reg[pulses] = out_reg;
            cap_val[pulses] = out_val;
         end
         if (pulses > 0 && low_run < min_low) min_low = low_run;
         pulses++;
         low_run = 0;
      end else if (!out_wr) low_run++;
      prev_wr = out_wr;
      if (out_busy) begin
         if (!prev_busy) busy_events++;
         busy_run++;
      end else if (prev_busy) begin
         last_busy_len = busy_run;
         busy_run = 0;
      end
      prev_busy = out_busy;
      // advance the model across the coming rising edge
      if (in_rst) begin
         m_live = 1; m_run = 0; m_phase = 0; m_wait = 0;
         m_done = 0; m_err = 0; m_have = 0; m_nargs = 0;
         e_reg = 6'd0; e_val = 8'd0;
      end else if (m_live) begin
         tick = !pause_v && (m_run % CPS == 0);
         if (!pause_v) m_run++;
         if (m_phase > 0) m_phase--;
         if (m_wait > 0 && tick) m_wait--;
         if (in_valid && out_ready) model_consume(in_data);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bit ok = 0;
      in_data = b;
      in_valid = 1'b1;
      for (int i = 0; i < 4000 && !ok; i++) begin
         @(negedge clk);
         if (out_ready) ok = 1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic drive_ignored(input logic [7:0] b, input int n);
      in_data = b;
      in_valid = 1'b1;
      idle(n);
      in_valid = 1'b0;
   endtask

   task automatic wait_ready();
      bit ok = 0;
      for (int i = 0; i < 4000 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (out_ready && !out_busy) ok = 1;
      end
      if (!ok) check("ready_timeout", 0, 1);
      idle(1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 in_rst = 1'b1;
      @(posedge clk);
      #1 in_rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, out_ready, 1);
      check({tag, "_reg"},   out_reg,   0);
      check({tag, "_val"},   out_val,   0);
      check({tag, "_wr"},    out_wr,    0);
      check({tag, "_busy"},  out_busy,  0);
      check({tag, "_done"},  out_done,  0);
      check({tag, "_error"}, out_error, 0);
   endtask

   initial begin
      int p0, b0, d1, d2;
      in_rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; pause_v = 1'b0;
      repeat (2) @(posedge clk);
      #1 in_rst = 1'b0;
      check_reset_outputs("por");

      // two writes back-to-back, valid held high
      send(8'hB3); send(8'h12); send(8'hF3);
      send(8'hB3); send(8'h13); send(8'h80);
      idle(5);
      check("wr_pair_pulses", pulses, 2);
      check("wr1_reg", cap_reg[0], 'h12);
      check("wr1_val", cap_val[0], 'hF3);
      check("wr2_reg", cap_reg[1], 'h13);
      check("wr2_val", cap_val[1], 'h80);
      check("wr_low_gap_ok", min_low >= 1, 1);

      // 3-sample wait then a write
      send(8'h61); send(8'h03); send(8'h00);
      check("wait3_busy", out_busy, 1);
      wait_ready();
      check("wait3_len_ok", last_busy_len >= 9 && last_busy_len <= 12, 1);
      send(8'hB3); send(8'h01); send(8'h80);
      idle(4);
      check("wr3_reg", cap_reg[2], 'h01);
      check("wr3_val", cap_val[2], 'h80);

      // zero-length wait
      b0 = busy_events;
      send(8'h61); send(8'h00); send(8'h00);
      check("wait0_ready", out_ready, 1);
      idle(3);
      check("wait0_no_busy", busy_events, b0);

      // 0x7F: 16 samples
      send(8'h7F);
      wait_ready();
      check("wait16_len_ok", last_busy_len >= 61 && last_busy_len <= 64, 1);

      // 0x62: 735 samples
      send(8'h62);
      wait_ready();
      check("wait735_len_ok", last_busy_len >= 2937 && last_busy_len <= 2940, 1);

      // out-of-range address dropped
      p0 = pulses;
      send(8'hB3); send(8'h40); send(8'h55);
      check("drop_ready", out_ready, 1);
      idle(4);
      check("drop_no_wr", pulses, p0);

      // end of data
      send(8'h66);
      check("done_flag", out_done, 1);
      check("done_ready", out_ready, 0);
      drive_ignored(8'hB3, 10);
      check("done_sticky", out_done, 1);
      check("done_no_err", out_error, 0);
      check("done_no_wr", pulses, p0);

      // unsupported command
      do_reset();
      check_reset_outputs("rst1");
      send(8'h4F);
      drive_ignored(8'h00, 5);
      check("err_flag", out_error, 1);
      check("err_no_done", out_done, 0);
      check("err_no_wr", pulses, p0);

      do_reset();
      check_reset_outputs("rst2");
      send(8'hB3); send(8'h00); send(8'h77);
      idle(4);
      check("post_rst_pulses", pulses, p0 + 1);
      check("post_rst_reg", cap_reg[p0], 'h00);
      check("post_rst_val", cap_val[p0], 'h77);

      // reset during a 500-sample wait
      send(8'h61); send(8'hF4); send(8'h01);
      idle(20);
      check("w500_busy", out_busy, 1);
      p0 = pulses;
      do_reset();
      check("w500_rst_busy", out_busy, 0);
      idle(20);
      check("w500_no_wr", pulses, p0);
      check("w500_ready", out_ready, 1);

`ifdef GBDMG_VGM_PAUSE_EN
      do_reset();
      idle(3);
      send(8'h7F);
      wait_ready();
      d1 = last_busy_len;
      do_reset();
      idle(3);
      send(8'h7F);
      idle(10);
      pause_v = 1'b1;
      idle(100);
      check("pause_busy_held", out_busy, 1);
      pause_v = 1'b0;
      wait_ready();
      d2 = last_busy_len;
      check("pause_extends_100", d2 - d1, 100);
`else
      d1 = 0; d2 = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
